// File: rtl/sr_ff_pkg.sv
// Shared encodings for the SR flip-flop response checker.
// FSM state codes and sampled {S,R} stimulus codes.
package sr_ff_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_FAIL = 2'd2;

    localparam logic [1:0] SR_HOLD    = 2'b00;
    localparam logic [1:0] SR_RESET   = 2'b01;
    localparam logic [1:0] SR_SET     = 2'b10;
    localparam logic [1:0] SR_ILLEGAL = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = ST_IDLE,
        S_RUN  = ST_RUN,
        S_FAIL = ST_FAIL
    } chk_state_e;

endpackage

// File: rtl/sr_ff_checker_sat_counter.sv
// Saturating up-counter with synchronous clear.
// Holds at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != '1)) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/sr_ff_checker.sv
// Cycle-accurate SR flip-flop reference model and response checker.
// q at edge k is compared against the expectation registered at edge k-1.
module sr_ff_checker
    import sr_ff_pkg::*;
#(
    parameter int CNT_W       = 8,
    parameter bit STOP_ON_ERR = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic             s,
    input  logic             r,
    input  logic             q,
    output logic             err,
    output logic             illegal,
    output logic             fail,
    output logic [CNT_W-1:0] err_cnt,
    output logic [CNT_W-1:0] illegal_cnt,
    output logic [CNT_W-1:0] chk_cnt,
    output logic [CNT_W-1:0] first_err_idx,
    output logic [1:0]       state
);

    chk_state_e st;
    logic       exp_q;
    logic       exp_known;
    logic [1:0] sr;
    logic       live;
    logic       do_cmp;
    logic       mis;
    logic       ill_hit;

    assign sr      = {s, r};
    assign live    = (st != S_FAIL);
    assign do_cmp  = (st == S_RUN) && exp_known;
    assign mis     = do_cmp && (q != exp_q);
    assign ill_hit = (st == S_RUN) && (sr == SR_ILLEGAL);
    assign state   = st;

    sat_counter #(.W(CNT_W)) u_err_cnt (
        .clk (clk),
        .rst (rst),
        .clr (clr),
        .inc (mis),
        .cnt (err_cnt)
    );

    sat_counter #(.W(CNT_W)) u_illegal_cnt (
        .clk (clk),
        .rst (rst),
        .clr (clr),
        .inc (ill_hit),
        .cnt (illegal_cnt)
    );

    sat_counter #(.W(CNT_W)) u_chk_cnt (
        .clk (clk),
        .rst (rst),
        .clr (clr),
        .inc (do_cmp),
        .cnt (chk_cnt)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st            <= S_IDLE;
            exp_q         <= 1'b0;
            exp_known     <= 1'b1;
            err           <= 1'b0;
            illegal       <= 1'b0;
            fail          <= 1'b0;
            first_err_idx <= '0;
        end else if (clr) begin
            st            <= S_IDLE;
            exp_q         <= 1'b0;
            exp_known     <= 1'b1;
            err           <= 1'b0;
            illegal       <= 1'b0;
            fail          <= 1'b0;
            first_err_idx <= '0;
        end else begin
            err     <= mis;
            illegal <= ill_hit;

            // Index captured before this compare bumps chk_cnt
            if (mis && !fail) begin
                fail          <= 1'b1;
                first_err_idx <= chk_cnt;
            end

            unique case (st)
                S_IDLE: begin
                    if (en) st <= S_RUN;
                end
                S_RUN: begin
                    if (mis && STOP_ON_ERR) st <= S_FAIL;
                    else if (!en)           st <= S_IDLE;
                end
                S_FAIL: st <= S_FAIL;
                default: st <= S_IDLE;
            endcase

            // Model keeps tracking in IDLE; frozen only in FAIL
            if (live) begin
                unique case (1'b1)
                    (sr == SR_SET): begin
                        exp_q     <= 1'b1;
                        exp_known <= 1'b1;
                    end
                    (sr == SR_RESET): begin
                        exp_q     <= 1'b0;
                        exp_known <= 1'b1;
                    end
                    (sr == SR_ILLEGAL): exp_known <= 1'b0;
                    (sr == SR_HOLD): ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sr_ff_checker.sv
// Bench for sr_ff_checker: three instances (default, stop-on-error,
// 2-bit counters) against a behavioural model of the checking rules.
module tb_sr_ff_checker;

    logic clk;
    logic rst;
    logic clr;
    logic en;
    logic s;
    logic r;
    logic q;
    logic ffq;
    logic stuck0;
    logic flip;
    bit   run_chk;

    logic       err0, ill0, fail0;
    logic [7:0] ec0, ic0, cc0, fi0;
    logic [1:0] st0;
    logic       err1, ill1, fail1;
    logic [7:0] ec1, ic1, cc1, fi1;
    logic [1:0] st1;
    logic       err2, ill2, fail2;
    logic [1:0] ec2, ic2, cc2, fi2;
    logic [1:0] st2;

    int passed;
    int total;

    typedef struct {
        int st, known, expq, err, ill, fail, ec, ic, cc, fi;
    } mdl_t;

    mdl_t m[3];
    int   mw[3]    = '{8, 8, 2};
    bit   mstop[3] = '{1'b0, 1'b1, 1'b0};

    sr_ff_checker #(.CNT_W(8), .STOP_ON_ERR(1'b0)) u0 (
        .clk(clk), .rst(rst), .clr(clr), .en(en),
        .s(s), .r(r), .q(q),
        .err(err0), .illegal(ill0), .fail(fail0),
        .err_cnt(ec0), .illegal_cnt(ic0), .chk_cnt(cc0),
        .first_err_idx(fi0), .state(st0)
    );

    sr_ff_checker #(.CNT_W(8), .STOP_ON_ERR(1'b1)) u1 (
        .clk(clk), .rst(rst), .clr(clr), .en(en),
        .s(s), .r(r), .q(q),
        .err(err1), .illegal(ill1), .fail(fail1),
        .err_cnt(ec1), .illegal_cnt(ic1), .chk_cnt(cc1),
        .first_err_idx(fi1), .state(st1)
    );

    sr_ff_checker #(.CNT_W(2), .STOP_ON_ERR(1'b0)) u2 (
        .clk(clk), .rst(rst), .clr(clr), .en(en),
        .s(s), .r(r), .q(q),
        .err(err2), .illegal(ill2), .fail(fail2),
        .err_cnt(ec2), .illegal_cnt(ic2), .chk_cnt(cc2),
        .first_err_idx(fi2), .state(st2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Observed flip-flop; S=R=1 leaves it in a random state
    always @(posedge clk or posedge rst) begin
        if (rst)             ffq <= 1'b0;
        else if (s && !r)    ffq <= 1'b1;
        else if (!s && r)    ffq <= 1'b0;
        else if (s && r)     ffq <= (($urandom & 1) == 1);
    end

    assign q = stuck0 ? 1'b0 : (ffq ^ flip);

    function automatic void mreset(int i);
        m[i] = '{default: 0};
        m[i].known = 1;
    endfunction

    function automatic int inc_sat(int v, int mx);
        return (v < mx) ? v + 1 : mx;
    endfunction

    function automatic void mstep(int i);
        int mx;
        mx = (1 << mw[i]) - 1;
        if (clr) begin
            mreset(i);
            return;
        end
        m[i].err = 0;
        m[i].ill = 0;
        if (m[i].st == 2) return;
        if (m[i].st == 1) begin
            if (m[i].known != 0) begin
                if (int'(q) != m[i].expq) begin
                    m[i].err = 1;
                    if (m[i].fail == 0) begin
                        m[i].fail = 1;
                        m[i].fi   = m[i].cc;
                    end
                    m[i].ec = inc_sat(m[i].ec, mx);
                end
                m[i].cc = inc_sat(m[i].cc, mx);
            end
            if (s && r) begin
                m[i].ill = 1;
                m[i].ic  = inc_sat(m[i].ic, mx);
            end
            if (m[i].err != 0 && mstop[i]) m[i].st = 2;
            else if (!en)                  m[i].st = 0;
        end else if (en) begin
            m[i].st = 1;
        end
        if (s && !r) begin
            m[i].expq  = 1;
            m[i].known = 1;
        end else if (!s && r) begin
            m[i].expq  = 0;
            m[i].known = 1;
        end else if (s && r) begin
            m[i].known = 0;
        end
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) for (int i = 0; i < 3; i++) mreset(i);
        else     for (int i = 0; i < 3; i++) mstep(i);
    end

    task automatic cmp(string nm, int act, int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d at %0t",
                      nm, act, exp, $time);
    endtask

    task automatic cmp_dut(int i, int e, int il, int f, int ec,
                           int ic, int cc, int fi, int st);
        cmp($sformatf("u%0d.err", i),           e,  m[i].err);
        cmp($sformatf("u%0d.illegal", i),       il, m[i].ill);
        cmp($sformatf("u%0d.fail", i),          f,  m[i].fail);
        cmp($sformatf("u%0d.err_cnt", i),       ec, m[i].ec);
        cmp($sformatf("u%0d.illegal_cnt", i),   ic, m[i].ic);
        cmp($sformatf("u%0d.chk_cnt", i),       cc, m[i].cc);
        cmp($sformatf("u%0d.first_err_idx", i), fi, m[i].fi);
        cmp($sformatf("u%0d.state", i),         st, m[i].st);
    endtask

    always @(negedge clk) begin
        if (run_chk) begin
            cmp_dut(0, err0, ill0, fail0, ec0, ic0, cc0, fi0, st0);
            cmp_dut(1, err1, ill1, fail1, ec1, ic1, cc1, fi1, st1);
            cmp_dut(2, err2, ill2, fail2, ec2, ic2, cc2, fi2, st2);
        end
    end

    task automatic step(bit s_, bit r_, bit e_, bit c_);
        s   = s_;
        r   = r_;
        en  = e_;
        clr = c_;
        @(posedge clk);
        #1;
    endtask

    initial begin
        passed  = 0;
        total   = 0;
        run_chk = 1'b0;
        rst     = 1'b1;
        clr     = 1'b0;
        en      = 1'b0;
        s       = 1'b0;
        r       = 1'b0;
        stuck0  = 1'b0;
        flip    = 1'b0;

        #2;
        cmp("reset.state", st0, 0);
        cmp("reset.err_cnt", ec0, 0);
        cmp("reset.fail", fail0, 0);
        cmp("reset.chk_cnt", cc0, 0);
        run_chk = 1'b1;
        #10 rst = 1'b0;
        @(posedge clk);
        #1;

        // Correct flip-flop: 00 enters RUN, then four compares
        step(0, 0, 1, 0);
        step(1, 0, 1, 0);
        step(0, 1, 1, 0);
        step(0, 0, 1, 0);
        step(0, 0, 1, 0);
        cmp("t1.chk_cnt", cc0, 4);
        cmp("t1.err_cnt", ec0, 0);
        cmp("t1.fail", fail0, 0);
        cmp("t1.u2_chk_sat", cc2, 3);

        // Q stuck at 0
        step(0, 1, 0, 1);
        stuck0 = 1'b1;
        step(0, 0, 1, 0);
        step(1, 0, 1, 0);
        step(0, 1, 1, 0);
        cmp("t2.err_pulse", err0, 1);
        step(0, 0, 1, 0);
        cmp("t2.err_drop", err0, 0);
        cmp("t2.err_cnt", ec0, 1);
        cmp("t2.fail", fail0, 1);
        cmp("t2.first_err_idx", fi0, 1);
        cmp("t2.stop_state", st1, 2);
        stuck0 = 1'b0;
        for (int k = 0; k < 10; k++)
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1, 0);
        cmp("t2.frozen_state", st1, 2);
        cmp("t2.frozen_chk", cc1, 2);
        cmp("t2.frozen_err", ec1, 1);
        cmp("t2.frozen_ill", ic1, 0);
        step(0, 1, 0, 1);
        cmp("t2.clr_state", st1, 0);
        cmp("t2.clr_err", ec1, 0);
        cmp("t2.clr_chk", cc1, 0);
        cmp("t2.clr_fail", fail1, 0);

        // Illegal stimulus pauses compares until 01
        step(0, 0, 1, 0);
        step(1, 0, 1, 0);
        step(1, 1, 1, 0);
        cmp("t3.ill_pulse", ill0, 1);
        cmp("t3.chk_two", cc0, 2);
        step(0, 0, 1, 0);
        cmp("t3.ill_drop", ill0, 0);
        step(0, 0, 1, 0);
        step(0, 1, 1, 0);
        cmp("t3.chk_paused", cc0, 2);
        step(0, 0, 1, 0);
        cmp("t3.chk_resumed", cc0, 3);
        cmp("t3.ill_cnt", ic0, 1);
        cmp("t3.err_cnt", ec0, 0);

        // Five forced mismatches saturate the 2-bit instance
        step(0, 1, 0, 1);
        step(0, 0, 1, 0);
        step(1, 0, 1, 0);
        flip = 1'b1;
        for (int k = 0; k < 5; k++) step(1, 0, 1, 0);
        flip = 1'b0;
        cmp("t4.u2_err_sat", ec2, 3);
        cmp("t4.u2_first_idx", fi2, 1);
        cmp("t4.u0_err_cnt", ec0, 5);
        cmp("t4.u0_first_idx", fi0, 1);

        // Asynchronous reset between edges
        #2 rst = 1'b1;
        #1;
        cmp("t5.state", st0, 0);
        cmp("t5.err_cnt", ec0, 0);
        cmp("t5.chk_cnt", cc0, 0);
        cmp("t5.fail", fail0, 0);
        cmp("t5.first_idx", fi0, 0);
        #1 rst = 1'b0;
        step(1, 0, 1, 0);
        step(0, 0, 1, 0);
        cmp("t5.no_err", err0, 0);
        cmp("t5.chk_one", cc0, 1);
        cmp("t5.err_cnt_after", ec0, 0);

        // Randomized traffic
        for (int k = 0; k < 400; k++) begin
            bit rs, rr;
            rs = 1'($urandom_range(0, 1));
            rr = 1'($urandom_range(0, 1));
            if (rs && rr && ($urandom_range(0, 3) != 0)) rr = 1'b0;
            flip = ($urandom_range(0, 19) == 0);
            step(rs, rr, ($urandom_range(0, 15) != 0),
                 ($urandom_range(0, 49) == 0));
        end
        flip = 1'b0;
        step(0, 0, 0, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/sr_ff_checker.md
Name: sr_ff_checker

Overview:
- Synthesizable response checker for the SR flip-flop block.
- Observes the S, R and Q signals of an SR flip-flop sharing its clock and reset.
- Runs a cycle-accurate reference model of the flip-flop, flags mismatches and illegal S=R=1 stimulus, and keeps saturating statistics.
- Sits beside the flip-flop in simulation and on-chip self-test, so stimulus generators need no self-checking logic.

Parameters:
- CNT_W, 8, width of all counters and the captured error index.
- STOP_ON_ERR, 0, if 1 the first mismatch moves the FSM to FAIL and freezes all counters.

Ports:
- clk  in  1  single clock; posedge only; same clock as the observed flip-flop.
- rst  in  1  reset, asynchronous and active-high; resets checker and model.
- clr  in  1  synchronous clear: counters to 0, FSM to IDLE, model to Q=0 known.
- en  in  1  check enable; level-sensitive.
- s  in  1  observed S input of the flip-flop.
- r  in  1  observed R input of the flip-flop.
- q  in  1  observed Q output of the flip-flop.
- err  out  1  one-cycle pulse on a Q mismatch.
- illegal  out  1  one-cycle pulse when S=R=1 is sampled in RUN.
- fail  out  1  sticky; set on the first mismatch.
- err_cnt  out  CNT_W  mismatch count; saturates at all-ones.
- illegal_cnt  out  CNT_W  S=R=1 count; saturates.
- chk_cnt  out  CNT_W  number of compared cycles; saturates.
- first_err_idx  out  CNT_W  chk_cnt value at the first mismatch.
- state  out  2  FSM state: IDLE=0, RUN=1, FAIL=2.

Behaviour:
- Reset (rst=1, async):
  - All outputs go to 0; state=IDLE.
  - Model exp_q=0 and exp_known=1, matching the flip-flop's reset value Q=0.
- Flip-flop contract checked, for the sampled S,R at each edge:
  - 10 sets Q=1.
  - 01 clears Q=0.
  - 00 holds Q.
  - 11 is illegal; Q is undefined afterwards.
- Timing: at posedge k, q holds the result of edge k-1.
  - Compare q against exp_q, which was registered from s,r at edge k-1.
  - Then update exp_q from s,r sampled at edge k.
  - Effective latency is one cycle from stimulus to check.
  - err is registered; it is high during the cycle after the mismatching edge.
- Model update applies in every state except FAIL (frozen), so the model tracks even while IDLE:
  - 10: exp_q=1, exp_known=1.
  - 01: exp_q=0, exp_known=1.
  - 00: hold both.
  - 11: exp_known=0.
- Compare rule:
  - Compare only in RUN with exp_known=1.
  - Each compare increments chk_cnt.
  - When exp_known=0, no compare and chk_cnt is not incremented. The next 10 or 01 restores tracking.
- FSM:
  - IDLE -> RUN when en=1.
  - RUN -> IDLE when en=0; counters retained.
  - RUN -> FAIL on mismatch when STOP_ON_ERR=1. With STOP_ON_ERR=0, stay in RUN.
  - FAIL -> IDLE only on clr or rst.
- First mismatch:
  - first_err_idx is captured with the pre-increment chk_cnt.
  - fail is set.
  - Later mismatches do not overwrite first_err_idx.
- Simultaneous events:
  - clr beats en, mismatch and illegal.
  - A mismatch and an illegal sample on the same edge both pulse and both count.
- Saturation: a counter at all-ones stays at all-ones; no wrap.
- Reset mid-run: rst forces IDLE immediately and asynchronously. Checking restarts on the first edge with en=1 after rst deasserts.

Decomposition:
- Shared package sr_ff_pkg:
  - FSM state encoding localparams (ST_IDLE, ST_RUN, ST_FAIL).
  - SR input code constants (SR_HOLD=2'b00, SR_RESET=2'b01, SR_SET=2'b10, SR_ILLEGAL=2'b11).
- Natural sub-module: sat_counter (CNT_W-bit saturating counter with inc and clr). Instantiated three times for err_cnt, illegal_cnt and chk_cnt.

Test Plan:
- Reset, then en=1 and drive SR = 00, 10, 01, 00 on one edge each against a correct flip-flop -> err never pulses; chk_cnt=4; fail=0; err_cnt=0.
- Same sequence against a flip-flop with Q stuck at 0 -> err pulses one cycle after the SR=10 edge; err_cnt=1; fail=1; first_err_idx=1.
- Drive SR = 10, 11, 00, 00, then 01 -> illegal pulses once; illegal_cnt=1.
  - No compares from the edge after 11 until after the 01 edge.
  - chk_cnt advances 2, pauses 3, then resumes.
- STOP_ON_ERR=1 with an injected mismatch -> state=2; counters frozen over 10 further edges; clr returns state=0 with all counters 0.
- CNT_W=2 with 5 consecutive forced mismatches (STOP_ON_ERR=0) -> err_cnt saturates at 3; first_err_idx unchanged after the first mismatch.
- Assert rst between edges mid-RUN -> all outputs 0 and state=0 immediately, before the next clk edge; SR=10 after release checks correctly with no err.
